// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: N-master single-outstanding bus arbiter with per-master
// hold registers, fixed-priority or round-robin grant, back-to-back issue.
// Ports: m_start/m_write/m_addr/m_data_wr (packed per master) in,
//        m_ready (one-hot) / m_data_rd (broadcast) out,
//        bus_start/bus_write/bus_addr/bus_data_wr out, bus_ready/bus_data_rd in,
//        owner/busy out (registered).
module core_bus_arbiter #(
  parameter int                   N_MASTERS   = 2,
  parameter int                   ADDR_W      = 30,
  parameter int                   DATA_W      = 32,
  parameter bit                   ROUND_ROBIN = 1'b0,
  parameter logic [N_MASTERS-1:0] WRITE_EN    = '1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_start,
  input  logic [N_MASTERS-1:0]          m_write,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_data_wr,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic [DATA_W-1:0]             m_data_rd,
  input  logic                          bus_ready,
  input  logic [DATA_W-1:0]             bus_data_rd,
  output logic                          bus_start,
  output logic                          bus_write,
  output logic [ADDR_W-1:0]             bus_addr,
  output logic [DATA_W-1:0]             bus_data_wr,
  output logic [$clog2(N_MASTERS)-1:0]  owner,
  output logic                          busy
);

  localparam int OW = $clog2(N_MASTERS);

  typedef enum logic {
    S_IDLE,
    S_ACTIVE
  } state_e;

  state_e                state_q, state_d;
  logic [N_MASTERS-1:0]  pend_q, pend_d;
  logic [N_MASTERS-1:0]  hwr_q, hwr_d;
  logic [ADDR_W-1:0]     haddr_q [N_MASTERS];
  logic [ADDR_W-1:0]     haddr_d [N_MASTERS];
  logic [DATA_W-1:0]     hdata_q [N_MASTERS];
  logic [DATA_W-1:0]     hdata_d [N_MASTERS];
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_q, last_d;
  logic                  busy_q, busy_d;

  logic [N_MASTERS-1:0]  req;
  logic [N_MASTERS-1:0]  f_wr;
  logic [ADDR_W-1:0]     f_addr [N_MASTERS];
  logic [DATA_W-1:0]     f_data [N_MASTERS];
  logic [OW-1:0]         win;
  logic [OW-1:0]         cand;
  logic                  found;
  logic                  issue;

  // Effective request fields: a held request shadows the live inputs.
  always_comb begin
    req = m_start | pend_q;
    f_wr = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      f_wr[i]   = pend_q[i] ? hwr_q[i] : m_write[i];
      f_addr[i] = pend_q[i] ? haddr_q[i]
                            : m_addr[i*ADDR_W +: ADDR_W];
      f_data[i] = pend_q[i] ? hdata_q[i]
                            : m_data_wr[i*DATA_W +: DATA_W];
    end
  end

  // Winner select. Round-robin walks from last_q+1 with a wrap at
  // N_MASTERS-1, so non-power-of-two counts need no modulo.
  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = last_q;
    if (ROUND_ROBIN) begin
      for (int k = 0; k < N_MASTERS; k++) begin
        cand = (cand == OW'(N_MASTERS - 1)) ? '0 : cand + 1'b1;
        if (!found && req[cand]) begin
          win   = cand;
          found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N_MASTERS; i++) begin
        if (req[i]) begin
          win   = OW'(i);
          found = 1'b1;
        end
      end
    end
  end

  // The bus is free when idle or when the current transfer completes now.
  assign issue = rst_n & found
               & ((state_q == S_IDLE) | bus_ready);

  always_comb begin
    bus_start   = issue;
    bus_write   = issue & f_wr[win] & WRITE_EN[win];
    bus_addr    = issue ? f_addr[win] : '0;
    bus_data_wr = bus_write ? f_data[win] : '0;
    m_ready     = '0;
    if (rst_n && state_q == S_ACTIVE && bus_ready) begin
      m_ready = N_MASTERS'(1) << owner_q;
    end
    m_data_rd   = rst_n ? bus_data_rd : '0;
  end

  assign owner = owner_q;
  assign busy  = busy_q;

  always_comb begin
    pend_d  = pend_q;
    hwr_d   = hwr_q;
    haddr_d = haddr_q;
    hdata_d = hdata_q;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (issue && win == OW'(i)) begin
        pend_d[i] = 1'b0;
      end else if (m_start[i]) begin
        pend_d[i]  = 1'b1;
        hwr_d[i]   = m_write[i];
        haddr_d[i] = m_addr[i*ADDR_W +: ADDR_W];
        hdata_d[i] = m_data_wr[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (issue) state_d = S_ACTIVE;
      S_ACTIVE: if (bus_ready && !issue) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    busy_d  = (state_d == S_ACTIVE);
    owner_d = issue ? win : owner_q;
    last_d  = issue ? win : last_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pend_q  <= '0;
      hwr_q   <= '0;
      for (int i = 0; i < N_MASTERS; i++) begin
        haddr_q[i] <= '0;
        hdata_q[i] <= '0;
      end
      owner_q <= '0;
      last_q  <= OW'(N_MASTERS - 1);
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hwr_q   <= hwr_d;
      haddr_q <= haddr_d;
      hdata_q <= hdata_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: random traffic on a 3-master round-robin arbiter
// and a 2-master fixed-priority arbiter, checked against a model.
module tb_core_bus_arbiter;

  logic clk;
  logic rst_n;

  logic [2:0]  rr_start, rr_write, rr_mready;
  logic [89:0] rr_addr;
  logic [95:0] rr_wd;
  logic [31:0] rr_mrd, rr_brd, rr_bd;
  logic        rr_brdy, rr_bs, rr_bw, rr_busy;
  logic [29:0] rr_ba;
  logic [1:0]  rr_owner;

  logic [1:0]  fx_start, fx_write, fx_mready;
  logic [59:0] fx_addr;
  logic [63:0] fx_wd;
  logic [31:0] fx_mrd, fx_brd, fx_bd;
  logic        fx_brdy, fx_bs, fx_bw, fx_busy;
  logic [29:0] fx_ba;
  logic [0:0]  fx_owner;

  core_bus_arbiter #(
    .N_MASTERS(3), .ADDR_W(30), .DATA_W(32),
    .ROUND_ROBIN(1'b1), .WRITE_EN(3'b011)
  ) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m_start(rr_start), .m_write(rr_write),
    .m_addr(rr_addr), .m_data_wr(rr_wd),
    .m_ready(rr_mready), .m_data_rd(rr_mrd),
    .bus_ready(rr_brdy), .bus_data_rd(rr_brd),
    .bus_start(rr_bs), .bus_write(rr_bw),
    .bus_addr(rr_ba), .bus_data_wr(rr_bd),
    .owner(rr_owner), .busy(rr_busy)
  );

  core_bus_arbiter #(
    .N_MASTERS(2), .ADDR_W(30), .DATA_W(32),
    .ROUND_ROBIN(1'b0), .WRITE_EN(2'b10)
  ) u_fx (
    .clk(clk), .rst_n(rst_n),
    .m_start(fx_start), .m_write(fx_write),
    .m_addr(fx_addr), .m_data_wr(fx_wd),
    .m_ready(fx_mready), .m_data_rd(fx_mrd),
    .bus_ready(fx_brdy), .bus_data_rd(fx_brd),
    .bus_start(fx_bs), .bus_write(fx_bw),
    .bus_addr(fx_ba), .bus_data_wr(fx_bd),
    .owner(fx_owner), .busy(fx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-instance configuration: 0 = round-robin, 1 = fixed priority.
  int       n_of   [2] = '{3, 2};
  bit       rr_of  [2] = '{1'b1, 1'b0};
  bit [2:0] wen_of [2] = '{3'b011, 3'b010};

  // Stimulus for the current cycle.
  bit          rst_v;
  bit          st   [2][3];
  bit          wr   [2][3];
  logic [29:0] ad   [2][3];
  logic [31:0] dw   [2][3];
  bit          brdy [2];
  logic [31:0] brd  [2];

  // Reference state: queued requests, who owns the bus, who went last.
  bit          pend  [2][3];
  bit          hwr   [2][3];
  logic [29:0] hadr  [2][3];
  logic [31:0] hdat  [2][3];
  bit          outst [2][3];
  bit          mbusy [2];
  int          own   [2];
  int          last  [2];

  task automatic model_reset(input int k);
    for (int i = 0; i < 3; i++) begin
      pend[k][i]  = 1'b0;
      outst[k][i] = 1'b0;
    end
    mbusy[k] = 1'b0;
    own[k]   = 0;
    last[k]  = n_of[k] - 1;
  endtask

  task automatic drive();
    rst_n = rst_v;
    for (int i = 0; i < 3; i++) begin
      rr_start[i]        = st[0][i];
      rr_write[i]        = wr[0][i];
      rr_addr[i*30 +: 30] = ad[0][i];
      rr_wd[i*32 +: 32]   = dw[0][i];
    end
    for (int i = 0; i < 2; i++) begin
      fx_start[i]        = st[1][i];
      fx_write[i]        = wr[1][i];
      fx_addr[i*30 +: 30] = ad[1][i];
      fx_wd[i*32 +: 32]   = dw[1][i];
    end
    rr_brdy = brdy[0];
    rr_brd  = brd[0];
    fx_brdy = brdy[1];
    fx_brd  = brd[1];
  endtask

  initial begin
    rst_v = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        st[k][i] = 1'b0;
        wr[k][i] = 1'b0;
        ad[k][i] = '0;
        dw[k][i] = '0;
      end
      brdy[k] = 1'b0;
      brd[k]  = '0;
      model_reset(k);
    end
    drive();

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      rst_v = (cyc < 2) ? 1'b0 : ($urandom_range(0, 149) != 0);
      for (int k = 0; k < 2; k++) begin
        bit comp;
        brdy[k] = 1'($urandom_range(0, 1));
        brd[k]  = $urandom;
        comp = rst_v && mbusy[k] && brdy[k];
        for (int i = 0; i < 3; i++) begin
          bit ok;
          ok = (i < n_of[k])
             && (!outst[k][i] || (comp && own[k] == i));
          st[k][i] = rst_v && ok && ($urandom_range(0, 2) == 0);
          wr[k][i] = 1'($urandom_range(0, 1));
          ad[k][i] = 30'($urandom);
          dw[k][i] = $urandom;
        end
      end
      drive();
      #1;
      for (int k = 0; k < 2; k++) begin
        bit          comp, req, ebs, ebw;
        int          n, win;
        logic [2:0]  emr;
        logic [29:0] eba;
        logic [31:0] ebd, emrd;
        logic [63:0] g_bs, g_bw, g_ba, g_bd, g_mr, g_mrd, g_own, g_busy;
        string       p;
        n    = n_of[k];
        comp = rst_v && mbusy[k] && brdy[k];
        emr  = comp ? 3'(1 << own[k]) : 3'b000;
        emrd = rst_v ? brd[k] : 32'h0;
        win  = -1;
        if (rst_v && (!mbusy[k] || brdy[k])) begin
          if (rr_of[k]) begin
            for (int j = 0; j < n; j++) begin
              int idx;
              idx = (last[k] + 1 + j) % n;
              req = st[k][idx] || pend[k][idx];
              if (win < 0 && req) win = idx;
            end
          end else begin
            for (int i = 0; i < n; i++) begin
              if (st[k][i] || pend[k][i]) win = i;
            end
          end
        end
        ebs = 1'b0;
        ebw = 1'b0;
        eba = '0;
        ebd = '0;
        if (win >= 0) begin
          ebs = 1'b1;
          if (pend[k][win]) begin
            ebw = hwr[k][win] && wen_of[k][win];
            eba = hadr[k][win];
            ebd = ebw ? hdat[k][win] : 32'h0;
          end else begin
            ebw = wr[k][win] && wen_of[k][win];
            eba = ad[k][win];
            ebd = ebw ? dw[k][win] : 32'h0;
          end
        end
        if (k == 0) begin
          g_bs = 64'(rr_bs);   g_bw = 64'(rr_bw);
          g_ba = 64'(rr_ba);   g_bd = 64'(rr_bd);
          g_mr = 64'(rr_mready); g_mrd = 64'(rr_mrd);
          g_own = 64'(rr_owner); g_busy = 64'(rr_busy);
        end else begin
          g_bs = 64'(fx_bs);   g_bw = 64'(fx_bw);
          g_ba = 64'(fx_ba);   g_bd = 64'(fx_bd);
          g_mr = 64'(fx_mready); g_mrd = 64'(fx_mrd);
          g_own = 64'(fx_owner); g_busy = 64'(fx_busy);
        end
        p = $sformatf("c%0d %s", cyc, (k == 0) ? "rr" : "fx");
        chk({p, " busy"},        g_busy, 64'(mbusy[k]));
        chk({p, " owner"},       g_own,  64'(own[k]));
        chk({p, " m_ready"},     g_mr,   64'(emr));
        chk({p, " m_data_rd"},   g_mrd,  64'(emrd));
        chk({p, " bus_start"},   g_bs,   64'(ebs));
        chk({p, " bus_write"},   g_bw,   64'(ebw));
        chk({p, " bus_addr"},    g_ba,   64'(eba));
        chk({p, " bus_data_wr"}, g_bd,   64'(ebd));

        if (!rst_v) begin
          model_reset(k);
        end else begin
          if (comp) outst[k][own[k]] = 1'b0;
          for (int i = 0; i < n; i++) begin
            if (win == i) begin
              pend[k][i] = 1'b0;
            end else if (st[k][i]) begin
              pend[k][i] = 1'b1;
              hwr[k][i]  = wr[k][i];
              hadr[k][i] = ad[k][i];
              hdat[k][i] = dw[k][i];
            end
            if (st[k][i]) outst[k][i] = 1'b1;
          end
          if (win >= 0) begin
            mbusy[k] = 1'b1;
            own[k]   = win;
            last[k]  = win;
          end else if (comp) begin
            mbusy[k] = 1'b0;
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
Parametrised N-master arbiter that multiplexes single-outstanding core bus requests (instruction fetch, data, future walkers/DMA) onto one shared bus port. Each master's start pulse is captured in a per-master hold register if the bus is not free that cycle, so no request is ever lost. Grants are issued back-to-back on bus_ready, using either fixed-priority or round-robin arbitration. Read data is broadcast to all masters and completion is routed to the owner only.

Parameters:
N_MASTERS, 2, number of masters (>=2); index N_MASTERS-1 is highest fixed priority
ADDR_W, 30, word address width (ptr)
DATA_W, 32, data width (word)
ROUND_ROBIN, 0, 0 = fixed priority, 1 = round-robin
WRITE_EN, all ones, per-master mask; bit i = 0 forces bus_write = 0 for master i (read-only master)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
m_start  in  N_MASTERS  one-cycle request pulse per master
m_write  in  N_MASTERS  write qualifier, valid with m_start
m_addr  in  N_MASTERS*ADDR_W  packed addresses; master i at [i*ADDR_W +: ADDR_W]
m_data_wr  in  N_MASTERS*DATA_W  packed write data, same packing
m_ready  out  N_MASTERS  completion pulse to owning master
m_data_rd  out  DATA_W  bus_data_rd broadcast to all masters
bus_ready  in  1  completion of the in-flight bus transaction
bus_data_rd  in  DATA_W  bus read data
bus_start  out  1  issue pulse
bus_write  out  1  write qualifier
bus_addr  out  ADDR_W  address
bus_data_wr  out  DATA_W  write data; 0 when bus_write = 0
owner  out  $clog2(N_MASTERS)  index of the master that owns the in-flight transaction
busy  out  1  transaction in flight

Behaviour:
- Protocol: a master asserts m_start for one cycle, with addr/write/data valid in that cycle only. It does not pulse again until its m_ready. A repeat pulse before m_ready is a protocol violation; the result is undefined and it is not tested.
- Request vector: req[i] = m_start[i] | pend[i]. When pend[i] is set, the transaction fields come from the hold register; otherwise they come from the live inputs.
- Hold: pend[i] is set, and fields latched, when m_start[i] arrives and master i is not issued that cycle. pend[i] clears in the cycle master i is issued.
- FSM IDLE:
  - If any req, select the winner and drive bus_start = 1 with its fields combinationally. Zero-cycle latency from a live m_start.
  - Then owner <= winner, busy <= 1, go to ACTIVE.
  - bus_ready is ignored in IDLE.
- FSM ACTIVE, bus_ready = 0: outputs hold; bus_start = 0.
- FSM ACTIVE, bus_ready = 1:
  - m_ready[owner] = 1 in the same cycle; m_data_rd = bus_data_rd.
  - If any req exists in that same cycle, including a new pulse from the just-completed owner, issue the winner in the same cycle (back-to-back) and stay in ACTIVE.
  - Otherwise go to IDLE, busy <= 0.
- Fixed priority: the highest index with req wins.
- Round-robin:
  - The search starts at (last_owner+1) mod N and wraps.
  - last_owner updates on each issue.
  - Reset value of last_owner is N_MASTERS-1, so master 0 wins the first tie.
- bus_write = m_write_sel & WRITE_EN[sel]. bus_data_wr = 0 whenever bus_write = 0.
- Outputs are driven only in the issue cycle; bus_start, bus_write, bus_addr and bus_data_wr are 0 otherwise.
- Reset (rst_n = 0 at posedge):
  - FSM goes to IDLE; all pend cleared; owner = 0; busy = 0; last_owner = N_MASTERS-1.
  - Outputs are gated to 0 while rst_n = 0.
  - An in-flight transaction is abandoned and no m_ready is produced for it. The bus slave shares the same reset.
- m_ready is one-hot or zero; never more than one bus_start per cycle.

Test Plan:
1. N=2 fixed: m_start[0] with addr 0x100, write 0, at cycle 0 -> bus_start = 1, bus_addr = 0x100 at cycle 0, busy = 1 from cycle 1. bus_ready at cycle 3 -> m_ready = 2'b01 at cycle 3 only, m_data_rd = bus_data_rd, busy = 0 at cycle 4.
2. N=2 fixed: simultaneous pulses, master 0 at addr 0x10 and master 1 write 0xDEADBEEF at addr 0x20 -> master 1 is issued first and pend[0] is set. On bus_ready, master 0 is issued in the same cycle from hold (addr 0x10), with m_ready = 2'b10 in that cycle.
3. N=3, ROUND_ROBIN=1: all masters re-pulse immediately after each m_ready -> grant order 0, 1, 2, 0, 1, with no idle cycles between transactions.
4. N=2, WRITE_EN=2'b10: master 0 pulses with m_write = 1 and m_data_wr = 0x12345678 -> bus_write = 0, bus_data_wr = 0. Master 1 write -> bus_write = 1 and its data passes through.
5. Back-to-back: owner 0 completes and m_start[0] pulses again in the same bus_ready cycle, with master 1 idle -> bus_start = 1 with master 0's new address in that cycle; busy stays 1.
6. Reset mid-op: rst_n low for 1 cycle while ACTIVE and with pend[1] set -> afterwards busy = 0, no m_ready, and no issue of master 1 until it pulses again.
